// File: rtl/stage_mm.sv
// stage_mm: memory-access stage; runs one data-memory req/ack per load/store and registers the writeback triple.
// Latency: 1 cycle for non-memory ops; k+2 edges for a memory op whose ack arrives k cycles after req rises.
// Backpressure: stall_out holds execute while a request is outstanding; stall_in freezes the output and holding registers.
module stage_mm #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  ex_valid,
  input  logic                  ex_reg_wr,
  input  logic [REG_ADDR_W-1:0] ex_reg_addr_rd,
  input  logic [DATA_W-1:0]     ex_alu_res,
  input  logic                  ex_mem_rd,
  input  logic                  ex_mem_wr,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_mem_unsigned,
  input  logic [DATA_W-1:0]     ex_store_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  stall_out,
  output logic                  misalign_err,
  output logic                  wb_flush,
  output logic                  wb_reg_wr,
  output logic [REG_ADDR_W-1:0] wb_reg_addr_rd,
  output logic [DATA_W-1:0]     wb_reg_data_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   kill;

  // Captured control for the in-flight transaction
  logic                  cap_load;
  logic                  cap_reg_wr;
  logic [REG_ADDR_W-1:0] cap_rd;
  logic [1:0]            cap_size;
  logic                  cap_unsigned;
  logic [1:0]            cap_off;

  // Holding register for a result completed under stall_in
  logic                  hold_flush;
  logic                  hold_reg_wr;
  logic [REG_ADDR_W-1:0] hold_rd;
  logic [DATA_W-1:0]     hold_data;

  logic                  is_mem;
  logic                  ex_misaligned;
  logic                  take;
  logic                  accept_mem;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [DATA_W-1:0]     load_data;
  logic                  res_flush;
  logic                  res_reg_wr;
  logic [REG_ADDR_W-1:0] res_rd;
  logic [DATA_W-1:0]     res_data;
  logic                  wb_ld;
  logic                  hold_ld;
  logic                  nxt_flush;
  logic                  nxt_reg_wr;
  logic [REG_ADDR_W-1:0] nxt_rd;
  logic [DATA_W-1:0]     nxt_data;
  logic [DATA_W-1:0]     st_wdata;
  logic [3:0]            st_be;

  // Acceptance decode: only IDLE takes ops, and never under stall or flush
  always_comb begin
    is_mem        = ex_mem_rd | ex_mem_wr;
    ex_misaligned = ((ex_mem_size == 2'b01) && ex_alu_res[0]) ||
                    (ex_mem_size[1] && (ex_alu_res[1:0] != 2'b00));
    take          = (state == IDLE) && ex_valid && !flush_in && !stall_in;
    accept_mem    = take && is_mem && !ex_misaligned;
    misalign_err  = take && is_mem && ex_misaligned;
    mem_req       = (state == BUSY);
    unique case (state)
      IDLE:    stall_out = accept_mem;
      BUSY:    stall_out = !mem_ack;
      default: stall_out = 1'b0;
    endcase
  end

  // Store lane replication and byte enables from size and address offset
  always_comb begin
    st_wdata = ex_store_data;
    st_be    = 4'b1111;
    if (ex_mem_size == 2'b00) begin
      st_wdata = {(DATA_W/8){ex_store_data[7:0]}};
      st_be    = 4'b0001 << ex_alu_res[1:0];
    end else if (ex_mem_size == 2'b01) begin
      st_wdata = {(DATA_W/16){ex_store_data[15:0]}};
      st_be    = ex_alu_res[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Load lane select and extension; a kill or a store turns the result into a bubble
  always_comb begin
    lane_b = mem_rdata[{cap_off, 3'b000} +: 8];
    lane_h = mem_rdata[{cap_off[1], 4'b0000} +: 16];
    if (cap_size == 2'b00)
      load_data = {{(DATA_W-8){~cap_unsigned & lane_b[7]}}, lane_b};
    else if (cap_size == 2'b01)
      load_data = {{(DATA_W-16){~cap_unsigned & lane_h[15]}}, lane_h};
    else
      load_data = mem_rdata;
    res_flush  = kill | flush_in | !cap_load;
    res_reg_wr = !res_flush & cap_reg_wr;
    res_rd     = res_flush ? '0 : cap_rd;
    res_data   = res_flush ? '0 : load_data;
  end

  // Next state and output-register load selection
  always_comb begin
    state_nxt  = state;
    wb_ld      = 1'b0;
    hold_ld    = 1'b0;
    nxt_flush  = 1'b1;
    nxt_reg_wr = 1'b0;
    nxt_rd     = '0;
    nxt_data   = '0;
    unique case (state)
      IDLE: begin
        if (!stall_in) begin
          wb_ld = 1'b1;
          if (take && !is_mem) begin
            nxt_flush  = 1'b0;
            nxt_reg_wr = ex_reg_wr;
            nxt_rd     = ex_reg_addr_rd;
            nxt_data   = ex_alu_res;
          end
          if (accept_mem) state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          if (!stall_in) begin
            wb_ld      = 1'b1;
            nxt_flush  = res_flush;
            nxt_reg_wr = res_reg_wr;
            nxt_rd     = res_rd;
            nxt_data   = res_data;
            state_nxt  = IDLE;
          end else begin
            hold_ld   = 1'b1;
            state_nxt = DONE;
          end
        end else if (!stall_in) begin
          wb_ld = 1'b1;
        end
      end
      DONE: begin
        if (!stall_in) begin
          wb_ld      = 1'b1;
          nxt_flush  = hold_flush;
          nxt_reg_wr = hold_reg_wr;
          nxt_rd     = hold_rd;
          nxt_data   = hold_data;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and sticky kill; kill clears whenever the FSM heads back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE)
        kill <= 1'b0;
      else if (state == BUSY && flush_in)
        kill <= 1'b1;
    end
  end

  // Request and transaction-control capture at acceptance; stable for the whole request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= 4'b0000;
      cap_load     <= 1'b0;
      cap_reg_wr   <= 1'b0;
      cap_rd       <= '0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_off      <= 2'b00;
    end else if (accept_mem) begin
      mem_we       <= ex_mem_wr;
      mem_addr     <= {ex_alu_res[ADDR_W-1:2], 2'b00};
      mem_wdata    <= st_wdata;
      mem_be       <= st_be;
      cap_load     <= ex_mem_rd;
      cap_reg_wr   <= ex_reg_wr;
      cap_rd       <= ex_reg_addr_rd;
      cap_size     <= ex_mem_size;
      cap_unsigned <= ex_mem_unsigned;
      cap_off      <= ex_alu_res[1:0];
    end
  end

  // Holding register for a result that completed while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_flush  <= 1'b1;
      hold_reg_wr <= 1'b0;
      hold_rd     <= '0;
      hold_data   <= '0;
    end else if (hold_ld) begin
      hold_flush  <= res_flush;
      hold_reg_wr <= res_reg_wr;
      hold_rd     <= res_rd;
      hold_data   <= res_data;
    end
  end

  // Writeback output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_flush       <= 1'b1;
      wb_reg_wr      <= 1'b0;
      wb_reg_addr_rd <= '0;
      wb_reg_data_rd <= '0;
    end else if (wb_ld) begin
      wb_flush       <= nxt_flush;
      wb_reg_wr      <= nxt_reg_wr;
      wb_reg_addr_rd <= nxt_rd;
      wb_reg_data_rd <= nxt_data;
    end
  end

endmodule

// File: tb/tb_stage_mm.sv
// tb_stage_mm: randomized and directed stimulus for stage_mm against an arithmetic reference model.
// Latency: drives one op at a time; checks combinational outputs #1 after driving, registered ones on the next falling edge.
// Backpressure: the bench plays the memory, choosing ack delay, and toggles stall_in/flush_in/reset explicitly.
module tb_stage_mm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in, flush_in, ex_valid, ex_reg_wr;
  logic [4:0]  ex_reg_addr_rd;
  logic [31:0] ex_alu_res;
  logic        ex_mem_rd, ex_mem_wr;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic [31:0] ex_store_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_out, misalign_err, wb_flush, wb_reg_wr;
  logic [4:0]  wb_reg_addr_rd;
  logic [31:0] wb_reg_data_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stage_mm dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .ex_valid(ex_valid), .ex_reg_wr(ex_reg_wr), .ex_reg_addr_rd(ex_reg_addr_rd),
    .ex_alu_res(ex_alu_res), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned), .ex_store_data(ex_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_out(stall_out),
    .misalign_err(misalign_err), .wb_flush(wb_flush), .wb_reg_wr(wb_reg_wr),
    .wb_reg_addr_rd(wb_reg_addr_rd), .wb_reg_data_rd(wb_reg_data_rd)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: access width in bytes, lane arithmetic on plain integers
  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input int off,
                                           input logic [1:0] sz, input bit uns);
    int nb;
    logic [31:0] v, mask;
    nb = nbytes_of(sz);
    v  = rd >> (8 * off);
    if (nb == 4) return v;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = v & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] sz);
    int nb;
    logic [31:0] w;
    nb = nbytes_of(sz);
    w  = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [3:0] ref_be(input int off, input logic [1:0] sz);
    int m;
    m = ((1 << nbytes_of(sz)) - 1) << off;
    return m[3:0];
  endfunction

  task automatic drive_op(input int kind, input bit fl, input logic [4:0] rd, input bit rw,
                          input logic [31:0] a, input logic [1:0] sz, input bit uns,
                          input logic [31:0] sd);
    ex_valid = 1'b1; flush_in = fl; ex_reg_wr = rw; ex_reg_addr_rd = rd; ex_alu_res = a;
    ex_mem_rd = (kind == 1); ex_mem_wr = (kind == 2); ex_mem_size = sz;
    ex_mem_unsigned = uns; ex_store_data = sd;
  endtask

  // One complete op: kind 0 ALU, 1 load, 2 store; k = ack delay in cycles after req rises
  task automatic do_op(input int kind, input bit fl, input logic [4:0] rd, input bit rw,
                       input logic [31:0] a, input logic [1:0] sz, input bit uns,
                       input logic [31:0] sd, input logic [31:0] rdat, input int k);
    int  off, scnt;
    bit  is_mem, mis;
    off    = int'(a[1:0]);
    is_mem = (kind != 0);
    mis    = is_mem && ((off % nbytes_of(sz)) != 0);
    @(negedge clk);
    drive_op(kind, fl, rd, rw, a, sz, uns, sd);
    #1;
    chk_eq("misalign_err", 32'(misalign_err), 32'(is_mem && !fl && mis));
    chk_eq("stall_accept", 32'(stall_out), 32'(is_mem && !fl && !mis));
    chk_eq("req_before", 32'(mem_req), 32'd0);
    if (fl || !is_mem || mis) begin
      @(negedge clk);
      ex_valid = 1'b0; flush_in = 1'b0;
      chk_eq("req_none", 32'(mem_req), 32'd0);
      if (fl || is_mem) begin
        chk_eq("bubble_flush", 32'(wb_flush), 32'd1);
        chk_eq("bubble_wr", 32'(wb_reg_wr), 32'd0);
      end else begin
        chk_eq("alu_flush", 32'(wb_flush), 32'd0);
        chk_eq("alu_wr", 32'(wb_reg_wr), 32'(rw));
        chk_eq("alu_rd", 32'(wb_reg_addr_rd), 32'(rd));
        chk_eq("alu_data", wb_reg_data_rd, a);
      end
      return;
    end
    scnt = 1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk_eq("req_up", 32'(mem_req), 32'd1);
    chk_eq("req_we", 32'(mem_we), 32'(kind == 2));
    chk_eq("req_addr", mem_addr, a & 32'hFFFF_FFFC);
    chk_eq("req_be", 32'(mem_be), 32'(ref_be(off, sz)));
    if (kind == 2) chk_eq("req_wdata", mem_wdata, ref_wdata(sd, sz));
    chk_eq("accept_bubble", 32'(wb_flush), 32'd1);
    for (int i = 0; i < k; i++) begin
      if (stall_out) scnt++;
      @(negedge clk);
      chk_eq("req_hold", 32'(mem_req), 32'd1);
      chk_eq("addr_stable", mem_addr, a & 32'hFFFF_FFFC);
    end
    mem_ack = 1'b1; mem_rdata = rdat;
    #1;
    chk_eq("stall_ack", 32'(stall_out), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    chk_eq("stall_cycles", 32'(scnt), 32'(k + 1));
    chk_eq("req_down", 32'(mem_req), 32'd0);
    if (kind == 1) begin
      chk_eq("ld_flush", 32'(wb_flush), 32'd0);
      chk_eq("ld_wr", 32'(wb_reg_wr), 32'(rw));
      chk_eq("ld_rd", 32'(wb_reg_addr_rd), 32'(rd));
      chk_eq("ld_data", wb_reg_data_rd, ref_load(rdat, off, sz, uns));
    end else begin
      chk_eq("st_flush", 32'(wb_flush), 32'd1);
      chk_eq("st_wr", 32'(wb_reg_wr), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b1; stall_in = 1'b0; flush_in = 1'b0; ex_valid = 1'b0; ex_reg_wr = 1'b0;
    ex_reg_addr_rd = '0; ex_alu_res = '0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
    ex_mem_size = 2'b00; ex_mem_unsigned = 1'b0; ex_store_data = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rst_wb_flush", 32'(wb_flush), 32'd1);
    chk_eq("rst_wb_wr", 32'(wb_reg_wr), 32'd0);
    chk_eq("rst_wb_rd", 32'(wb_reg_addr_rd), 32'd0);
    chk_eq("rst_wb_data", wb_reg_data_rd, 32'd0);
    chk_eq("rst_req", 32'(mem_req), 32'd0);
    chk_eq("rst_be", 32'(mem_be), 32'd0);
    chk_eq("rst_stall", 32'(stall_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(0, 0, 5'd7, 1, 32'h1234, 2'b00, 0, 0, 0, 0);
    do_op(1, 0, 5'd3, 1, 32'h103, 2'b00, 0, 0, 32'h80FF00AA, 2);
    chk_eq("plan_sbyte", wb_reg_data_rd, 32'hFFFFFF80);
    do_op(1, 0, 5'd4, 1, 32'h2, 2'b01, 1, 0, 32'h80FF00AA, 1);
    chk_eq("plan_uhalf", wb_reg_data_rd, 32'h000080FF);
    do_op(2, 0, 5'd0, 0, 32'h6, 2'b01, 0, 32'hABCD1234, 0, 0);
    do_op(1, 0, 5'd5, 1, 32'h5, 2'b10, 0, 0, 0, 0);

    // Stall blocks acceptance and holds the output register
    do_op(0, 0, 5'd3, 1, 32'hAAAA0001, 2'b00, 0, 0, 0, 0);
    stall_in = 1'b1;
    drive_op(0, 0, 5'd8, 1, 32'hBBBB0002, 2'b00, 0, 0);
    @(negedge clk);
    chk_eq("stall_hold_data", wb_reg_data_rd, 32'hAAAA0001);
    chk_eq("stall_hold_flush", 32'(wb_flush), 32'd0);
    stall_in = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    chk_eq("stall_release", wb_reg_data_rd, 32'hBBBB0002);

    // Ack under stall: DONE holds the result and ignores a new op in its release cycle
    drive_op(1, 0, 5'd9, 1, 32'h8, 2'b10, 0, 0);
    @(negedge clk);
    ex_valid = 1'b0; stall_in = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1 chk_eq("done_ack_stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk_eq("done_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk_eq("done_held", 32'(wb_flush), 32'd1);
    stall_in = 1'b0;
    drive_op(0, 0, 5'd1, 1, 32'h55, 2'b00, 0, 0);
    @(negedge clk);
    ex_valid = 1'b0;
    chk_eq("done_rel_flush", 32'(wb_flush), 32'd0);
    chk_eq("done_rel_rd", 32'(wb_reg_addr_rd), 32'd9);
    chk_eq("done_rel_data", wb_reg_data_rd, 32'hDEADBEEF);

    // Flush in first BUSY cycle, ack under stall: bubble released after stall drops
    drive_op(1, 0, 5'd4, 1, 32'h10, 2'b10, 0, 0);
    @(negedge clk);
    ex_valid = 1'b0; flush_in = 1'b1;
    #1 chk_eq("kill_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    flush_in = 1'b0; stall_in = 1'b1;
    chk_eq("kill_req_hold", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    #1 chk_eq("kill_ack_stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk_eq("kill_done_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    stall_in = 1'b0;
    @(negedge clk);
    chk_eq("kill_flush", 32'(wb_flush), 32'd1);
    chk_eq("kill_wr", 32'(wb_reg_wr), 32'd0);

    // Reset in BUSY drops mem_req at once; a late ack is ignored
    drive_op(1, 0, 5'd6, 1, 32'h20, 2'b10, 0, 0);
    @(negedge clk);
    ex_valid = 1'b0;
    chk_eq("rb_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_eq("rb_async_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1;
    #1 chk_eq("rb_ack_stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk_eq("rb_ack_req", 32'(mem_req), 32'd0);
    chk_eq("rb_ack_flush", 32'(wb_flush), 32'd1);

    // Randomized ops against the reference model
    for (int n = 0; n < 80; n++) begin
      int          kind, k;
      bit          fl, rw, uns;
      logic [31:0] a, sd, rdat;
      logic [4:0]  rd;
      logic [1:0]  sz;
      kind = $urandom_range(0, 2);
      fl   = ($urandom_range(0, 7) == 0);
      rw   = $urandom_range(0, 1) != 0;
      uns  = $urandom_range(0, 1) != 0;
      a    = $urandom & 32'h0000_0FFF;
      sd   = $urandom;
      rdat = $urandom;
      rd   = 5'($urandom_range(0, 31));
      sz   = 2'($urandom_range(0, 2));
      k    = $urandom_range(0, 3);
      do_op(kind, fl, rd, rw, a, sz, uns, sd, rdat, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_mm.md
# stage_mm

Memory-access pipeline stage between execute and writeback. It takes the execute result and, for loads and stores, runs one data-memory transaction over a req/ack handshake. It aligns and extends load data, then registers the write-back triple (enable, destination, data) plus a bubble flag for the writeback stage. It stalls the upstream pipeline while a transaction is outstanding and honours global stall and flush.

## Interface
- DATA_W, 32, datapath and memory word width (4 byte lanes)
- ADDR_W, 32, data-memory byte address width
- REG_ADDR_W, 5, register-file address width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall_in  in  1  global stall; output register and holding state freeze
- flush_in  in  1  kill the op currently presented by execute
- ex_valid  in  1  execute presents an op
- ex_reg_wr  in  1  op writes the register file
- ex_reg_addr_rd  in  REG_ADDR_W  destination register
- ex_alu_res  in  DATA_W  ALU result, also the memory byte address (low ADDR_W bits)
- ex_mem_rd / ex_mem_wr  in  1 each  load / store (never both)
- ex_mem_size  in  2  00 byte, 01 half, 10 word
- ex_mem_unsigned  in  1  zero-extend loads
- ex_store_data  in  DATA_W  store source
- mem_req  out  1  request valid, held until mem_ack
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_be  out  4  byte enables
- mem_rdata  in  DATA_W  read data, valid in mem_ack cycle
- mem_ack  in  1  transaction complete
- stall_out  out  1  hold execute
- misalign_err  out  1  one-cycle pulse for a dropped misaligned access
- wb_flush  out  1  bubble to writeback
- wb_reg_wr  out  1  write-back enable
- wb_reg_addr_rd  out  REG_ADDR_W  write-back destination
- wb_reg_data_rd  out  DATA_W  write-back data

## Operation
- FSM states:
  - IDLE: accepts ops from execute.
  - BUSY: mem_req=1 with registered mem_we, mem_addr, mem_wdata and mem_be.
  - DONE: holds a completed result while stall_in=1.
- IDLE, non-memory op (ex_valid, !flush_in, !stall_in): output register loads {wb_flush=0, ex_reg_wr, ex_reg_addr_rd, ex_alu_res}.
- IDLE, no op, or flush_in: output register loads a bubble (wb_flush=1, wb_reg_wr=0) unless stall_in=1.
- IDLE, memory op, not flushed:
  - Misaligned cases: half with addr[0]=1, or word with addr[1:0]≠0.
    - Misaligned: no request is issued, misalign_err=1 that cycle, a bubble is written, and execute advances.
    - Aligned: request registers and control (rd, reg_wr, size, unsigned, addr[1:0]) are captured, stall_out=1, and the FSM goes to BUSY.
- Any op arriving with stall_in=1 is not accepted. It is not captured and issues no request; execute holds it.
- BUSY:
  - stall_out=1 until the mem_ack cycle.
  - On mem_ack:
    - stall_out=0 that cycle, so execute advances at that edge.
    - If !stall_in, load the output register and go to IDLE.
    - Otherwise latch the result into a holding register and go to DONE.
- DONE: stall_out=0, mem_req=0. The first cycle with stall_in=0 loads the output register from the holding register and returns to IDLE; no new op is accepted in that cycle.
- Flush during BUSY:
  - The transaction cannot be cancelled: mem_req stays asserted until mem_ack.
  - A sticky kill bit is set, and the completed result is written as a bubble.
  - The kill bit clears on return to IDLE.
- Store encoding:
  - Byte: wdata = 4× data[7:0], be = 1<<addr[1:0].
  - Half: wdata = 2× data[15:0], be = 0011 or 1100.
  - Word: be = 1111.
  - Stores write a bubble to writeback.
- Load result: lane selected by addr[1:0] (little-endian), then zero- or sign-extended to DATA_W per ex_mem_unsigned.
- Reset: state IDLE, kill=0; all outputs 0 except wb_flush=1.
- Reset mid-transaction: mem_req drops immediately. Any later mem_ack while in IDLE is ignored.

## Timing
- Non-memory op: 1 cycle, execute input to wb_* outputs.
- Memory op accepted at edge E: mem_req rises after E. With ack k cycles after req rises (k≥0, same cycle allowed), wb_* updates at the edge ending the ack cycle. Total latency is k+2 edges.
- mem_addr, mem_we, mem_wdata and mem_be are stable for the whole time mem_req=1.
- stall_out is combinational from state, inputs and mem_ack.
- Outputs hold their value whenever stall_in=1.

## Test plan
- ALU op, ex_reg_addr_rd=7, ex_alu_res=0x1234 -> next cycle wb_flush=0, wb_reg_wr=1, addr 7, data 0x1234.
- Signed byte load, addr 0x103, rdata=0x80FF00AA, ack after 2 wait cycles:
  - mem_addr=0x100.
  - stall_out is high for 3 cycles.
  - Result wb_reg_data_rd=0xFFFFFF80.
- Unsigned half load, addr 0x2, same rdata -> 0x000080FF.
- Half store, addr 0x6, data 0xABCD1234 -> mem_we=1, mem_be=1100, mem_wdata=0x12341234, result is a bubble.
- Word load at addr 0x5 -> no mem_req, misalign_err pulses, bubble written, stall_out=0.
- Combined stall and flush case:
  - Load pending; flush_in asserted in its first BUSY cycle; ack arrives with stall_in=1.
  - Required: mem_req holds until ack, FSM enters DONE, and a bubble is released one cycle after stall_in drops.
  - Reset asserted mid-BUSY: mem_req falls asynchronously.
